decode_stage: RTL and testbench
===============================

// Module: decode_stage
// PURPOSE
//  Decode stage between the fetch instruction queue and dispatch/rename into the reservation stations.
//  Accepts one raw 32-bit instruction + PC per cycle over valid/ready and emits decoded fields:
//  opcode, funct3, register addresses, sign-extended immediate, ALU op and register-use flags.
//  Decode uses the rv32i_types encodings (rv32i_opcode, arith_funct3_t, alu_ops).
//  Two-entry skid buffer, so in_ready is registered. Latency 1 cycle.
// PARAMETERS
//  SKID_EN    1  1: two-entry skid buffer with registered in_ready. 0: one entry, in_ready = ~out_valid | out_ready.
//  CSR_LEGAL  0  1: op_csr decodes as a legal no-op writing rd. 0: op_csr flagged illegal.
// PORTS
//  clk            in   1   clock
//  rst_n          in   1   reset, asynchronous, active-low
//  flush          in   1   squash all buffered instructions (branch mispredict)
//  in_valid       in   1   fetch queue presents an instruction
//  in_ready       out  1   stage can accept this cycle
//  in_inst        in   32  raw instruction
//  in_pc          in   32  instruction PC
//  out_valid      out  1   decoded instruction available
//  out_ready      in   1   dispatch consumes this cycle
//  out_pc         out  32  PC of decoded instruction
//  out_inst       out  32  raw instruction (for rvfi_word)
//  out_opcode     out  7   inst[6:0]
//  out_funct3     out  3   inst[14:12]
//  out_rd         out  5   rd address, forced 0 when out_writes_rd = 0
//  out_rs1        out  5   rs1 address, forced 0 when unused
//  out_rs2        out  5   rs2 address, forced 0 when unused
//  out_imm        out  32  sign-extended immediate (I/S/B/U/J by opcode), 0 for op_reg
//  out_alu_op     out  3   alu_ops encoding
//  out_is_cmp     out  1   slt/sltu (imm or reg form); result comes from the comparator, not the ALU
//  out_uses_rs1   out  1   rs1 is a true source
//  out_uses_rs2   out  1   rs2 is a true source
//  out_writes_rd  out  1   instruction writes a nonzero rd
//  out_illegal    out  1   illegal or unsupported encoding
// BEHAVIOUR
//  Reset (async, rst_n=0)
//   - all outputs 0; both entries invalid; in_ready = 1 after release.
//  Storage
//   - Entries OUT and SKID, each holding valid + decoded fields.
//   - Decode is combinational on in_inst, registered on accept (in_valid & in_ready).
//  Accept routing
//   - OUT empty, or OUT consumed this cycle with SKID empty -> write OUT.
//   - Otherwise -> write SKID.
//   - OUT consumed with SKID valid -> SKID moves to OUT; an accept in the same cycle writes SKID.
//   - Order is always preserved.
//  in_ready
//   - Registered: in_ready = ~SKID.valid (next-state).
//   - Never 0 while both entries are empty.
//  Output holding
//   - While out_valid & ~out_ready, all out_* are held stable.
//  Flush
//   - Both entries invalid next cycle; in_ready = 1.
//   - An accept in the flush cycle is discarded.
//   - Flush has priority over accept and consume.
//  ALU op (op_imm / op_reg)
//   - add: alu_sub if op_reg & inst[30], else alu_add.
//   - sr: alu_sra if inst[30], else alu_srl.
//   - sll -> alu_sll; axor -> alu_xor; aor -> alu_or; aand -> alu_and.
//   - slt/sltu -> alu_add with out_is_cmp = 1.
//   - All other opcodes -> alu_add.
//  Register-use flags
//   - uses_rs1: jalr, br, load, store, imm, reg.
//   - uses_rs2: br, store, reg.
//   - writes_rd: lui, auipc, jal, jalr, load, imm, reg (and csr if CSR_LEGAL), only when rd != 0.
//  Immediates
//   - I = {{20{i[31]}}, i[31:20]}
//   - S = {{20{i[31]}}, i[31:25], i[11:7]}
//   - B = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 0}
//   - U = {i[31:12], 12'b0}
//   - J = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 0}
//  Illegal (still passed downstream with out_illegal = 1, all use flags = 0)
//   - unknown opcode; inst[1:0] != 2'b11
//   - load funct3 in {011, 110, 111}; store funct3 > 010; branch funct3 in {010, 011}
//   - op_reg funct7 not in {0000000, 0100000}, or 0100000 with funct3 not add/sr
//   - shift-imm funct7 invalid
//   - op_csr when CSR_LEGAL = 0
// TESTING
//  1. addi x1,x0,5 (0x00500093) @PC 0x60000000, out_ready=1
//     -> next cycle out_valid=1, rd=1, rs1=0, imm=5, alu_add, writes_rd=1, uses_rs2=0.
//  2. sub x3,x1,x2 (0x402081B3) -> alu_sub, rs1=1, rs2=2, uses_rs1=uses_rs2=1, imm=0.
//     beq x1,x2,-8 (0xFE208CE3) -> imm=0xFFFFFFF8, writes_rd=0, rd=0.
//  3. out_ready=0, present A, B, C back-to-back
//     -> A, B accepted; in_ready=0 the cycle after B; C held upstream.
//     Then raise out_ready -> A, B, C emerge in order, one per cycle.
//  4. Both entries full + in_valid=1 + flush=1 -> next cycle out_valid=0, in_ready=1; new inst never emitted.
//  5. 0xFFFFFFFF -> out_illegal=1, use flags 0.
//     csrrw 0x34011073 with CSR_LEGAL=0 -> out_illegal=1.
//     Same instruction with CSR_LEGAL=1 -> out_illegal=0, writes_rd=0 (rd=0).
//  6. Drop rst_n asynchronously mid-stream with entries full
//     -> out_valid=0 immediately (before next edge); after release in_ready=1 and no stale output.

Source files
------------

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV32I decode stage with two-entry skid buffer between fetch queue and dispatch
module decode_stage #(
    parameter logic SKID_EN   = 1'b1,
    parameter logic CSR_LEGAL = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_inst,
    input  logic [31:0] in_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    output logic [6:0]  out_opcode,
    output logic [2:0]  out_funct3,
    output logic [4:0]  out_rd,
    output logic [4:0]  out_rs1,
    output logic [4:0]  out_rs2,
    output logic [31:0] out_imm,
    output logic [2:0]  out_alu_op,
    output logic        out_is_cmp,
    output logic        out_uses_rs1,
    output logic        out_uses_rs2,
    output logic        out_writes_rd,
    output logic        out_illegal
);

    // rv32i_opcode encodings
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_REG   = 7'b0110011;
    localparam logic [6:0] OP_CSR   = 7'b1110011;

    // arith_funct3_t encodings
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    // alu_ops encodings
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SLL = 3'b001;
    localparam logic [2:0] ALU_SRA = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SRL = 3'b101;
    localparam logic [2:0] ALU_OR  = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  alu_op;
        logic        is_cmp;
        logic        uses_rs1;
        logic        uses_rs2;
        logic        writes_rd;
        logic        illegal;
    } entry_t;

    entry_t dec;
    entry_t out_q;
    entry_t skid_q;
    logic   out_v;
    logic   skid_v;
    logic   rdy_q;
    logic   skid_v_next;
    logic   accept;
    logic   consume;

    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;
    logic        use1;
    logic        use2;
    logic        wr;
    logic        bad;
    logic [2:0]  alu;
    logic        cmp;

    assign op    = in_inst[6:0];
    assign f3    = in_inst[14:12];
    assign f7    = in_inst[31:25];
    assign imm_i = {{20{in_inst[31]}}, in_inst[31:20]};
    assign imm_s = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
    assign imm_b = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
    assign imm_u = {in_inst[31:12], 12'b0};
    assign imm_j = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};

    // Combinational decode of the presented instruction; illegal encodings clear every use flag and ALU info
    always_comb begin
        use1    = 1'b0;
        use2    = 1'b0;
        wr      = 1'b0;
        bad     = 1'b0;
        alu     = ALU_ADD;
        cmp     = 1'b0;
        dec.imm = 32'b0;
        case (op)
            OP_LUI, OP_AUIPC: begin
                wr      = 1'b1;
                dec.imm = imm_u;
            end
            OP_JAL: begin
                wr      = 1'b1;
                dec.imm = imm_j;
            end
            OP_JALR: begin
                use1    = 1'b1;
                wr      = 1'b1;
                dec.imm = imm_i;
            end
            OP_BR: begin
                use1    = 1'b1;
                use2    = 1'b1;
                dec.imm = imm_b;
                bad     = (f3 == 3'b010) || (f3 == 3'b011);
            end
            OP_LOAD: begin
                use1    = 1'b1;
                wr      = 1'b1;
                dec.imm = imm_i;
                bad     = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
            end
            OP_STORE: begin
                use1    = 1'b1;
                use2    = 1'b1;
                dec.imm = imm_s;
                bad     = (f3 > 3'b010);
            end
            OP_IMM: begin
                use1    = 1'b1;
                wr      = 1'b1;
                dec.imm = imm_i;
                bad     = ((f3 == F3_SLL) && (f7 != F7_BASE)) ||
                          ((f3 == F3_SR) && (f7 != F7_BASE) && (f7 != F7_ALT));
            end
            OP_REG: begin
                use1    = 1'b1;
                use2    = 1'b1;
                wr      = 1'b1;
                bad     = !((f7 == F7_BASE) ||
                            ((f7 == F7_ALT) && ((f3 == F3_ADD) || (f3 == F3_SR))));
            end
            OP_CSR: begin
                wr      = CSR_LEGAL;
                dec.imm = imm_i;
                bad     = ~CSR_LEGAL;
            end
            default: bad = 1'b1;
        endcase

        if ((op == OP_IMM) || (op == OP_REG)) begin
            case (f3)
                F3_ADD:  alu = ((op == OP_REG) && in_inst[30]) ? ALU_SUB : ALU_ADD;
                F3_SLL:  alu = ALU_SLL;
                F3_SLT,
                F3_SLTU: cmp = 1'b1;
                F3_XOR:  alu = ALU_XOR;
                F3_SR:   alu = in_inst[30] ? ALU_SRA : ALU_SRL;
                F3_OR:   alu = ALU_OR;
                F3_AND:  alu = ALU_AND;
                default: alu = ALU_ADD;
            endcase
        end

        if (bad) begin
            use1 = 1'b0;
            use2 = 1'b0;
            wr   = 1'b0;
            alu  = ALU_ADD;
            cmp  = 1'b0;
        end
        wr = wr && (in_inst[11:7] != 5'd0);

        dec.pc        = in_pc;
        dec.inst      = in_inst;
        dec.rd        = wr ? in_inst[11:7] : 5'd0;
        dec.rs1       = use1 ? in_inst[19:15] : 5'd0;
        dec.rs2       = use2 ? in_inst[24:20] : 5'd0;
        dec.alu_op    = alu;
        dec.is_cmp    = cmp;
        dec.uses_rs1  = use1;
        dec.uses_rs2  = use2;
        dec.writes_rd = wr;
        dec.illegal   = bad;
    end

    assign in_ready = SKID_EN ? rdy_q : (~out_v | out_ready);
    assign accept   = in_valid & in_ready;
    assign consume  = out_v & out_ready;

    // Next SKID occupancy, which also sets the registered in_ready
    always_comb begin
        skid_v_next = skid_v;
        if (flush) begin
            skid_v_next = 1'b0;
        end else if (!out_v || consume) begin
            skid_v_next = skid_v & accept;
        end else if (accept) begin
            skid_v_next = 1'b1;
        end
    end

    // Entry routing: refill OUT from SKID first, then from the input, so order is preserved
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_v  <= 1'b0;
            skid_v <= 1'b0;
            rdy_q  <= 1'b1;
            out_q  <= '0;
            skid_q <= '0;
        end else if (flush) begin
            out_v  <= 1'b0;
            skid_v <= 1'b0;
            rdy_q  <= 1'b1;
        end else begin
            if (!out_v || consume) begin
                if (skid_v) begin
                    out_q <= skid_q;
                    out_v <= 1'b1;
                    if (accept) begin
                        skid_q <= dec;
                    end
                end else begin
                    out_v <= accept;
                    if (accept) begin
                        out_q <= dec;
                    end
                end
            end else if (accept) begin
                skid_q <= dec;
            end
            skid_v <= skid_v_next;
            rdy_q  <= ~skid_v_next;
        end
    end

    assign out_valid     = out_v;
    assign out_pc        = out_q.pc;
    assign out_inst      = out_q.inst;
    assign out_opcode    = out_q.inst[6:0];
    assign out_funct3    = out_q.inst[14:12];
    assign out_rd        = out_q.rd;
    assign out_rs1       = out_q.rs1;
    assign out_rs2       = out_q.rs2;
    assign out_imm       = out_q.imm;
    assign out_alu_op    = out_q.alu_op;
    assign out_is_cmp    = out_q.is_cmp;
    assign out_uses_rs1  = out_q.uses_rs1;
    assign out_uses_rs2  = out_q.uses_rs2;
    assign out_writes_rd = out_q.writes_rd;
    assign out_illegal   = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - randomized self-checking bench for decode_stage against a queue-based reference
module tb_decode_stage;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  alu;
        logic        cmp;
        logic        u1;
        logic        u2;
        logic        wr;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_inst = 32'b0;
    logic [31:0] in_pc = 32'b0;
    logic        out_ready = 1'b0;

    logic        a_in_ready, a_out_valid, a_is_cmp, a_u1, a_u2, a_wr, a_ill;
    logic [31:0] a_pc, a_inst, a_imm;
    logic [6:0]  a_opcode;
    logic [2:0]  a_funct3, a_alu;
    logic [4:0]  a_rd, a_rs1, a_rs2;

    logic        b_in_ready, b_out_valid, b_is_cmp, b_u1, b_u2, b_wr, b_ill;
    logic [31:0] b_pc, b_inst, b_imm;
    logic [6:0]  b_opcode;
    logic [2:0]  b_funct3, b_alu;
    logic [4:0]  b_rd, b_rs1, b_rs2;

    int   n_checks = 0;
    int   n_fail = 0;
    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;

    decode_stage #(.SKID_EN(1'b1), .CSR_LEGAL(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_pc(a_pc), .out_inst(a_inst),
        .out_opcode(a_opcode), .out_funct3(a_funct3), .out_rd(a_rd), .out_rs1(a_rs1),
        .out_rs2(a_rs2), .out_imm(a_imm), .out_alu_op(a_alu), .out_is_cmp(a_is_cmp),
        .out_uses_rs1(a_u1), .out_uses_rs2(a_u2), .out_writes_rd(a_wr), .out_illegal(a_ill)
    );

    decode_stage #(.SKID_EN(1'b1), .CSR_LEGAL(1'b1)) dut_csr (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_pc(b_pc), .out_inst(b_inst),
        .out_opcode(b_opcode), .out_funct3(b_funct3), .out_rd(b_rd), .out_rs1(b_rs1),
        .out_rs2(b_rs2), .out_imm(b_imm), .out_alu_op(b_alu), .out_is_cmp(b_is_cmp),
        .out_uses_rs1(b_u1), .out_uses_rs2(b_u2), .out_writes_rd(b_wr), .out_illegal(b_ill)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference decode from the ISA tables: format selects the immediate, class selects the flags
    function automatic exp_t ref_decode(input logic [31:0] i, input logic [31:0] pc, input bit csr_legal);
        exp_t        e;
        int          fmt = 0;   // 0 none, 1 I, 2 S, 3 B, 4 U, 5 J
        logic [2:0]  f3 = i[14:12];
        logic [6:0]  f7 = i[31:25];
        bit          src1 = 0, src2 = 0, dst = 0, bad = 0, arith = 0;
        logic [2:0]  alu_tab [8] = '{3'd0, 3'd1, 3'd0, 3'd0, 3'd4, 3'd5, 3'd6, 3'd7};
        case (i[6:0])
            7'h37, 7'h17: begin fmt = 4; dst = 1; end
            7'h6F: begin fmt = 5; dst = 1; end
            7'h67: begin fmt = 1; src1 = 1; dst = 1; end
            7'h63: begin fmt = 3; src1 = 1; src2 = 1; bad = (f3 == 2 || f3 == 3); end
            7'h03: begin fmt = 1; src1 = 1; dst = 1; bad = (f3 == 3 || f3 >= 6); end
            7'h23: begin fmt = 2; src1 = 1; src2 = 1; bad = (f3 > 2); end
            7'h13: begin
                fmt = 1; src1 = 1; dst = 1; arith = 1;
                bad = (f3 == 1 && f7 != 0) || (f3 == 5 && f7 != 0 && f7 != 7'h20);
            end
            7'h33: begin
                src1 = 1; src2 = 1; dst = 1; arith = 1;
                bad = !(f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5)));
            end
            7'h73: begin fmt = 1; dst = csr_legal; bad = !csr_legal; end
            default: bad = 1;
        endcase
        e.pc   = pc;
        e.inst = i;
        case (fmt)
            1: e.imm = {{20{i[31]}}, i[31:20]};
            2: e.imm = {{20{i[31]}}, i[31:25], i[11:7]};
            3: e.imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            4: e.imm = {i[31:12], 12'b0};
            5: e.imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default: e.imm = 32'd0;
        endcase
        e.alu = 3'd0;
        e.cmp = 1'b0;
        if (arith && !bad) begin
            e.alu = alu_tab[f3];
            if (f3 == 0 && i[6:0] == 7'h33 && i[30]) e.alu = 3'd3;
            if (f3 == 5 && i[30]) e.alu = 3'd2;
            e.cmp = (f3 == 2 || f3 == 3);
        end
        e.ill = bad;
        e.u1  = src1 && !bad;
        e.u2  = src2 && !bad;
        e.wr  = dst && !bad && (i[11:7] != 0);
        e.rd  = e.wr ? i[11:7] : 5'd0;
        e.rs1 = e.u1 ? i[19:15] : 5'd0;
        e.rs2 = e.u2 ? i[24:20] : 5'd0;
        return e;
    endfunction

    task automatic cmp_entry(input string who, input exp_t o, input exp_t e);
        check({who, ".pc"}, o.pc, e.pc);
        check({who, ".inst"}, o.inst, e.inst);
        check({who, ".opcode_funct3"}, {o.inst[14:12], o.inst[6:0]}, {e.inst[14:12], e.inst[6:0]});
        check({who, ".imm"}, o.imm, e.imm);
        check({who, ".rd"}, o.rd, e.rd);
        check({who, ".rs1"}, o.rs1, e.rs1);
        check({who, ".rs2"}, o.rs2, e.rs2);
        check({who, ".alu_op"}, o.alu, e.alu);
        check({who, ".flags"}, {o.cmp, o.u1, o.u2, o.wr, o.ill}, {e.cmp, e.u1, e.u2, e.wr, e.ill});
    endtask

    // Compare both DUTs with their models; model occupancy defines out_valid and in_ready
    task automatic compare_outputs();
        exp_t oa, ob;
        check("a.out_valid", a_out_valid, q0.size() != 0);
        check("a.in_ready", a_in_ready, q0.size() < 2);
        check("b.out_valid", b_out_valid, q1.size() != 0);
        check("b.in_ready", b_in_ready, q1.size() < 2);
        oa = '{a_pc, a_inst, a_imm, a_rd, a_rs1, a_rs2, a_alu, a_is_cmp, a_u1, a_u2, a_wr, a_ill};
        ob = '{b_pc, b_inst, b_imm, b_rd, b_rs1, b_rs2, b_alu, b_is_cmp, b_u1, b_u2, b_wr, b_ill};
        oa.inst = {a_inst[31:15], a_funct3, a_inst[11:7], a_opcode};
        ob.inst = {b_inst[31:15], b_funct3, b_inst[11:7], b_opcode};
        if (q0.size() != 0) cmp_entry("a", oa, q0[0]);
        if (q1.size() != 0) cmp_entry("b", ob, q1[0]);
    endtask

    // One cycle: check what the last edge produced, then drive and advance the model for the next edge
    task automatic step(input logic iv, input logic [31:0] inst, input logic [31:0] pc,
                        input logic ordy, input logic fl);
        bit acc, con;
        @(negedge clk);
        compare_outputs();
        in_valid  = iv;
        in_inst   = inst;
        in_pc     = pc;
        out_ready = ordy;
        flush     = fl;
        if (fl) begin
            q0.delete();
            q1.delete();
        end else begin
            con = (q0.size() != 0) && ordy;
            acc = iv && (q0.size() < 2);
            if (con) begin
                void'(q0.pop_front());
                void'(q1.pop_front());
            end
            if (acc) begin
                q0.push_back(ref_decode(inst, pc, 1'b0));
                q1.push_back(ref_decode(inst, pc, 1'b1));
            end
        end
    endtask

    function automatic logic [31:0] rand_inst();
        logic [6:0]  ops [10] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h73};
        logic [31:0] r = $urandom;
        int          sel = $urandom_range(0, 11);
        int          f7s = $urandom_range(0, 3);
        logic [6:0]  f7;
        if (sel >= 10) return r;
        f7 = (f7s == 0) ? 7'h00 : (f7s == 1) ? 7'h20 : r[31:25];
        return {f7, r[24:7], ops[sel]};
    endfunction

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst.out_valid", a_out_valid, 1'b0);
        check("rst.fields", {a_pc ^ a_inst ^ a_imm}, 32'd0);
        check("rst.regs", {a_rd, a_rs1, a_rs2, a_alu, a_is_cmp, a_u1, a_u2, a_wr, a_ill}, 24'd0);
        rst_n = 1'b1;
        step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        check("rst.in_ready", a_in_ready, 1'b1);

        // addi x1,x0,5
        step(1'b1, 32'h00500093, 32'h60000000, 1'b1, 1'b0);
        step(1'b1, 32'h402081B3, 32'h60000004, 1'b1, 1'b0);
        check("addi.imm", a_imm, 32'd5);
        check("addi.rd", a_rd, 5'd1);
        check("addi.alu", a_alu, 3'd0);
        check("addi.wr_u2", {a_wr, a_u2}, 2'b10);
        step(1'b1, 32'hFE208CE3, 32'h60000008, 1'b1, 1'b0);
        check("sub.alu", a_alu, 3'd3);
        check("sub.rs", {a_rs1, a_rs2}, {5'd1, 5'd2});
        check("sub.imm", a_imm, 32'd0);
        step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        check("beq.imm", a_imm, 32'hFFFFFFF8);
        check("beq.rd_wr", {a_rd, a_wr}, 6'd0);

        // Backpressure: A, B accepted, C held until out_ready returns
        step(1'b1, 32'h00A00113, 32'h100, 1'b0, 1'b0);
        step(1'b1, 32'h00B00193, 32'h104, 1'b0, 1'b0);
        step(1'b1, 32'h00C00213, 32'h108, 1'b0, 1'b0);
        check("bp.in_ready_low", a_in_ready, 1'b0);
        step(1'b1, 32'h00C00213, 32'h108, 1'b0, 1'b0);
        step(1'b1, 32'h00C00213, 32'h108, 1'b1, 1'b0);
        step(1'b1, 32'h00C00213, 32'h108, 1'b1, 1'b0);
        step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        check("bp.c_out", a_inst, 32'h00C00213);
        step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);

        // Flush with both entries full and a new instruction presented
        step(1'b1, 32'h00100293, 32'h200, 1'b0, 1'b0);
        step(1'b1, 32'h00200313, 32'h204, 1'b0, 1'b0);
        step(1'b1, 32'h00300393, 32'h208, 1'b0, 1'b1);
        step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        check("flush.state", {a_out_valid, a_in_ready}, 2'b01);
        step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        check("flush.no_emit", a_out_valid, 1'b0);

        // Illegal encodings and CSR legality
        step(1'b1, 32'hFFFFFFFF, 32'h300, 1'b1, 1'b0);
        step(1'b1, 32'h34011073, 32'h304, 1'b1, 1'b0);
        check("ill.ones", {a_ill, a_u1, a_u2, a_wr}, 4'b1000);
        step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        check("csr.illegal0", a_ill, 1'b1);
        check("csr.legal1", {b_ill, b_wr, b_rd}, 7'd0);

        // Asynchronous reset with both entries full
        step(1'b1, 32'h00400413, 32'h400, 1'b0, 1'b0);
        step(1'b1, 32'h00500493, 32'h404, 1'b0, 1'b0);
        @(negedge clk);
        compare_outputs();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst.out_valid", a_out_valid, 1'b0);
        check("arst.pc", a_pc, 32'd0);
        q0.delete();
        q1.delete();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        check("arst.in_ready", a_in_ready, 1'b1);
        check("arst.stale", a_out_valid, 1'b0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(0, 3) != 0, rand_inst(), $urandom & 32'hFFFFFFFC,
                 $urandom_range(0, 2) != 0, $urandom_range(0, 39) == 0);
        end
        step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
